// File: rtl/sp_float_pkg.sv
// Shared single-precision float definitions for the sp_* arithmetic units:
// F32 field widths, exponent bias and the common conversion FSM encoding.
package sp_float_pkg;

  localparam int F32_EXP_W  = 8;
  localparam int F32_MANT_W = 23;
  localparam int F32_BIAS   = 127;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } sp_state_e;

endpackage : sp_float_pkg

// File: rtl/sp_f32_round_rne.sv
// Round-to-nearest-even of a normalised 24-bit significand to an F32 mantissa,
// bumping the exponent when rounding carries out of the significand.
module sp_f32_round_rne
  import sp_float_pkg::*;
(
  input  logic [F32_MANT_W:0]   sig,
  input  logic                  guard,
  input  logic                  sticky,
  input  logic [F32_EXP_W:0]    exp_in,
  output logic [F32_MANT_W-1:0] mant,
  output logic [F32_EXP_W:0]    exp_out
);

  logic round_up;
  logic carry;

  assign round_up = guard & (sticky | sig[0]);
  // Carry out only when the whole significand is ones; the fraction then wraps to zero.
  assign carry    = round_up & (&sig);
  assign mant     = sig[F32_MANT_W-1:0] + F32_MANT_W'(round_up);
  assign exp_out  = exp_in + (F32_EXP_W+1)'(carry);

endmodule : sp_f32_round_rne

// File: rtl/sp_i2f_f32.sv
// Iterative signed-integer to F32 converter: captures |a|, normalises one bit
// per cycle, then rounds once. Low rst restarts a conversion.
module sp_i2f_f32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  output logic [31:0]      result,
  output logic             ready
);

  import sp_float_pkg::*;

  localparam int MW = WIDTH + 24;

  sp_state_e              state, state_nxt;
  logic                   sign;
  logic [F32_EXP_W:0]     exp;
  logic [MW-1:0]          m;
  logic [WIDTH-1:0]       a_mag;
  logic                   a_zero;
  logic [F32_MANT_W-1:0]  r_mant;
  logic [F32_EXP_W:0]     r_exp;

  // Unsigned magnitude: the most-negative input maps to 2^(WIDTH-1) cleanly.
  assign a_mag  = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
  assign a_zero = (a == '0);

  always_ff @(posedge clk) begin
    if (!rst) state <= LOAD;
    else      state <= state_nxt;
  end

  // NORM looks one bit ahead so the shift that normalises M also enters ROUND.
  always_comb begin
    state_nxt = state;
    case (state)
      LOAD: begin
        if (a_zero)              state_nxt = DONE;
        else if (a_mag[WIDTH-1]) state_nxt = ROUND;
        else                     state_nxt = NORM;
      end
      NORM:    if (m[MW-2]) state_nxt = ROUND;
      ROUND:   state_nxt = DONE;
      DONE:    state_nxt = DONE;
      default: state_nxt = LOAD;
    endcase
  end

  always_comb begin
    ready = (state == DONE);
  end

  // NOTE: sign/exp/M are always loaded in LOAD before use, so they need no reset.
  always_ff @(posedge clk) begin
    case (state)
      LOAD: begin
        sign <= a[WIDTH-1];
        m    <= {a_mag, 24'b0};
        exp  <= (F32_EXP_W+1)'(F32_BIAS + WIDTH - 1);
      end
      NORM: begin
        m   <= m << 1;
        exp <= exp - 9'd1;
      end
      ROUND:   exp <= r_exp;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      result <= '0;
    end else if (state == LOAD && a_zero) begin
      result <= '0;
    end else if (state == ROUND) begin
      result <= {sign, r_exp[F32_EXP_W-1:0], r_mant};
    end
  end

  sp_f32_round_rne u_round (
    .sig     (m[MW-1 -: 24]),
    .guard   (m[WIDTH-1]),
    .sticky  (|m[WIDTH-2:0]),
    .exp_in  (exp),
    .mant    (r_mant),
    .exp_out (r_exp)
  );

endmodule : sp_i2f_f32

// File: tb/tb_sp_i2f_f32.sv
// Directed self-checking bench for sp_i2f_f32 (WIDTH=32): results, exact
// latency, rounding ties, carry, most-negative input and mid-operation reset.
module tb_sp_i2f_f32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] a   = '0;
  logic [31:0] result;
  logic        ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sp_i2f_f32 #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .result (result),
    .ready  (ready)
  );

  // One reset edge with operand applied, then release at the next negedge.
  task automatic start_conv(input logic [31:0] val);
    @(negedge clk);
    rst = 1'b0;
    a   = val;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Counts edges after release until ready; edges=0 means the budget expired.
  task automatic wait_ready(output int edges, output logic [31:0] res);
    edges = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (ready === 1'b1) begin
        edges = i;
        break;
      end
    end
    res = result;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    a   = 32'd1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (ready !== 1'b0 || result !== 32'h0) begin
        errors++;
        $display("FAIL reset_state: ready=%b result=%h, expected ready=0 result=00000000", ready, result);
      end
    end
  endtask

  task automatic test_zero();
    int          edges;
    logic [31:0] res;
    start_conv(32'd0);
    wait_ready(edges, res);
    checks++;
    if (edges !== 1) begin
      errors++;
      $display("FAIL zero_latency: got %0d edges, expected 1", edges);
    end
    checks++;
    if (res !== 32'h0) begin
      errors++;
      $display("FAIL zero_result: got %h, expected 00000000", res);
    end
    // DONE ignores a and holds its outputs.
    a = 32'd5;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ready !== 1'b1 || result !== 32'h0) begin
      errors++;
      $display("FAIL done_hold: ready=%b result=%h, expected ready=1 result=00000000", ready, result);
    end
  endtask

  task automatic test_one_latency();
    int          edges;
    logic [31:0] res;
    start_conv(32'd1);
    wait_ready(edges, res);
    checks++;
    if (edges !== 33) begin
      errors++;
      $display("FAIL one_latency: got %0d edges, expected 33", edges);
    end
    checks++;
    if (res !== 32'h3F800000) begin
      errors++;
      $display("FAIL one_result: got %h, expected 3f800000", res);
    end
  endtask

  task automatic test_negative_round();
    int          edges;
    logic [31:0] res;
    start_conv(32'(-1234124124));
    wait_ready(edges, res);
    checks++;
    if (edges !== 3 || res !== 32'hCE931E7B) begin
      errors++;
      $display("FAIL neg_round: got %h after %0d edges, expected ce931e7b after 3", res, edges);
    end
  endtask

  task automatic test_most_negative();
    int          edges;
    logic [31:0] res;
    start_conv(32'h80000000);
    wait_ready(edges, res);
    checks++;
    if (edges !== 2 || res !== 32'hCF000000) begin
      errors++;
      $display("FAIL most_negative: got %h after %0d edges, expected cf000000 after 2", res, edges);
    end
  endtask

  task automatic test_carry();
    int          edges;
    logic [31:0] res;
    start_conv(32'd2147483584);
    wait_ready(edges, res);
    checks++;
    if (edges !== 3 || res !== 32'h4F000000) begin
      errors++;
      $display("FAIL mant_carry: got %h after %0d edges, expected 4f000000 after 3", res, edges);
    end
  endtask

  task automatic test_ties();
    int          edges;
    logic [31:0] res;
    start_conv(32'd16777217);
    wait_ready(edges, res);
    checks++;
    if (edges !== 9 || res !== 32'h4B800000) begin
      errors++;
      $display("FAIL tie_even_down: got %h after %0d edges, expected 4b800000 after 9", res, edges);
    end
    start_conv(32'd16777219);
    wait_ready(edges, res);
    checks++;
    if (edges !== 9 || res !== 32'h4B800002) begin
      errors++;
      $display("FAIL tie_even_up: got %h after %0d edges, expected 4b800002 after 9", res, edges);
    end
  endtask

  task automatic test_mid_reset();
    int          edges;
    logic [31:0] res;
    start_conv(32'd1);
    for (int i = 1; i <= 9; i++) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_before_reset: ready=%b after 9 edges, expected 0", ready);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (ready !== 1'b0 || result !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset_state: ready=%b result=%h, expected ready=0 result=00000000", ready, result);
    end
    @(negedge clk);
    rst = 1'b1;
    wait_ready(edges, res);
    checks++;
    if (edges !== 33 || res !== 32'h3F800000) begin
      errors++;
      $display("FAIL mid_restart: got %h after %0d edges, expected 3f800000 after 33", res, edges);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vec_a   [4] = '{32'hFFFFFFFF, 32'd3, 32'h7FFFFFFF, 32'd100};
    logic [31:0] vec_res [4] = '{32'hBF800000, 32'h40400000, 32'h4F000000, 32'h42C80000};
    int          vec_lat [4] = '{33, 32, 3, 27};
    int          edges;
    logic [31:0] res;
    for (int v = 0; v < 4; v++) begin
      @(negedge clk);
      rst = 1'b0;
      a   = vec_a[v];
      @(posedge clk);
      #1;
      if (v > 0) begin
        // The previous nonzero result must be cleared by the restart.
        checks++;
        if (result !== 32'h0 || ready !== 1'b0) begin
          errors++;
          $display("FAIL b2b_clear[%0d]: ready=%b result=%h, expected ready=0 result=00000000", v, ready, result);
        end
      end
      @(negedge clk);
      rst = 1'b1;
      wait_ready(edges, res);
      checks++;
      if (edges !== vec_lat[v] || res !== vec_res[v]) begin
        errors++;
        $display("FAIL b2b[%0d] a=%h: got %h after %0d edges, expected %h after %0d",
                 v, vec_a[v], res, edges, vec_res[v], vec_lat[v]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_one_latency();
    test_negative_round();
    test_most_negative();
    test_carry();
    test_ties();
    test_mid_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_sp_i2f_f32
